// File: rtl/mem_bus_arbiter.sv
// Two-master arbiter for the data-memory port: round-robin with read-modify-write lock.
// Optional macro ARB_LOCK_LIMIT_EN caps consecutive locked re-grants at LOCK_MAX.
`timescale 1ns/1ps
module mem_bus_arbiter #(
    parameter int LOCK_MAX = 4
) (
    input  logic        clk_pi,
    input  logic        reset_pi,
    input  logic        clk_en,
    input  logic        m0_req_pi,
    input  logic        m0_write_pi,
    input  logic [15:0] m0_addr_pi,
    input  logic [15:0] m0_wdata_pi,
    input  logic        m0_lock_pi,
    output logic        m0_gnt_po,
    output logic        m0_ack_po,
    output logic [15:0] m0_rdata_po,
    input  logic        m1_req_pi,
    input  logic        m1_write_pi,
    input  logic [15:0] m1_addr_pi,
    input  logic [15:0] m1_wdata_pi,
    input  logic        m1_lock_pi,
    output logic        m1_gnt_po,
    output logic        m1_ack_po,
    output logic [15:0] m1_rdata_po,
    output logic [15:0] mem_addr_po,
    output logic [15:0] mem_wdata_po,
    output logic        mem_write_po,
    input  logic [15:0] mem_rdata_pi,
    output logic        busy_po
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ACC0 = 2'd1;
    localparam logic [1:0] ST_ACC1 = 2'd2;

    logic [1:0]  r_state;
    logic        r_last_gnt;
    logic        r_lock_vld;
    logic        r_lock_own;
    logic        r_gnt0;
    logic        r_gnt1;
    logic        r_busy;
    logic        r_ack0;
    logic        r_ack1;
    logic [15:0] r_rdata0;
    logic [15:0] r_rdata1;

    logic [1:0]  w_state_nxt;
    logic        w_last_gnt_nxt;
    logic        w_lock_vld_nxt;
    logic        w_lock_own_nxt;
    logic        w_done0;
    logic        w_done1;
    logic        w_owner_req;
    logic        w_other_req;
    logic        w_lock_hit;
    logic        w_force_other;

    assign w_owner_req = r_lock_own ? m1_req_pi : m0_req_pi;
    assign w_other_req = r_lock_own ? m0_req_pi : m1_req_pi;
    assign w_lock_hit  = r_lock_vld & w_owner_req;

`ifdef ARB_LOCK_LIMIT_EN
    localparam int LOCK_CW = (LOCK_MAX < 2) ? 1 : $clog2(LOCK_MAX + 1);

    logic [LOCK_CW-1:0] r_lock_cnt;
    logic               w_cnt_inc;
    logic               w_cnt_clr;

    assign w_force_other = (r_lock_cnt == LOCK_CW'(LOCK_MAX));

    // Counts locked re-grants that keep the other master waiting.
    always_comb begin
        w_cnt_inc = 1'b0;
        w_cnt_clr = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (r_lock_vld && !w_owner_req) begin
                    w_cnt_clr = 1'b1;
                end else if (w_lock_hit && w_other_req && w_force_other) begin
                    w_cnt_clr = 1'b1;
                end else if (w_lock_hit && w_other_req) begin
                    w_cnt_inc = 1'b1;
                end else begin
                    w_cnt_inc = 1'b0;
                end
            end
            ST_ACC0: begin
                if (m0_req_pi && !m0_lock_pi) begin
                    w_cnt_clr = 1'b1;
                end else begin
                    w_cnt_clr = 1'b0;
                end
            end
            ST_ACC1: begin
                if (m1_req_pi && !m1_lock_pi) begin
                    w_cnt_clr = 1'b1;
                end else begin
                    w_cnt_clr = 1'b0;
                end
            end
            default: w_cnt_clr = 1'b1;
        endcase
    end

    // Lock-limit counter register.
    always_ff @(posedge clk_pi or negedge reset_pi) begin
        if (!reset_pi) begin
            r_lock_cnt <= {LOCK_CW{1'b0}};
        end else if (clk_en) begin
            if (w_cnt_clr) begin
                r_lock_cnt <= {LOCK_CW{1'b0}};
            end else if (w_cnt_inc) begin
                r_lock_cnt <= r_lock_cnt + {{(LOCK_CW-1){1'b0}}, 1'b1};
            end
        end
    end
`else
    assign w_force_other = 1'b0;
`endif

    // Arbitration in IDLE; completion or abort of the access in ACCESS_N.
    always_comb begin
        w_state_nxt    = r_state;
        w_last_gnt_nxt = r_last_gnt;
        w_lock_vld_nxt = r_lock_vld;
        w_lock_own_nxt = r_lock_own;
        w_done0        = 1'b0;
        w_done1        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (r_lock_vld && !w_owner_req) begin
                    w_lock_vld_nxt = 1'b0;
                end else begin
                    w_lock_vld_nxt = r_lock_vld;
                end
                if (w_lock_hit && !(w_force_other && w_other_req)) begin
                    w_state_nxt    = r_lock_own ? ST_ACC1 : ST_ACC0;
                    w_last_gnt_nxt = r_lock_own;
                end else if (w_lock_hit) begin
                    w_state_nxt    = r_lock_own ? ST_ACC0 : ST_ACC1;
                    w_last_gnt_nxt = ~r_lock_own;
                end else if (m0_req_pi && (!m1_req_pi || r_last_gnt)) begin
                    w_state_nxt    = ST_ACC0;
                    w_last_gnt_nxt = 1'b0;
                end else if (m1_req_pi) begin
                    w_state_nxt    = ST_ACC1;
                    w_last_gnt_nxt = 1'b1;
                end else begin
                    w_state_nxt    = ST_IDLE;
                end
            end
            ST_ACC0: begin
                w_state_nxt = ST_IDLE;
                if (m0_req_pi) begin
                    w_done0        = 1'b1;
                    w_lock_vld_nxt = m0_lock_pi;
                    w_lock_own_nxt = 1'b0;
                end else begin
                    w_done0        = 1'b0;
                end
            end
            ST_ACC1: begin
                w_state_nxt = ST_IDLE;
                if (m1_req_pi) begin
                    w_done1        = 1'b1;
                    w_lock_vld_nxt = m1_lock_pi;
                    w_lock_own_nxt = 1'b1;
                end else begin
                    w_done1        = 1'b0;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // State, arbitration history and registered master-side outputs; ack clears every clk_pi edge.
    always_ff @(posedge clk_pi or negedge reset_pi) begin
        if (!reset_pi) begin
            r_state    <= ST_IDLE;
            r_last_gnt <= 1'b1;
            r_lock_vld <= 1'b0;
            r_lock_own <= 1'b0;
            r_gnt0     <= 1'b0;
            r_gnt1     <= 1'b0;
            r_busy     <= 1'b0;
            r_ack0     <= 1'b0;
            r_ack1     <= 1'b0;
            r_rdata0   <= 16'h0000;
            r_rdata1   <= 16'h0000;
        end else begin
            r_ack0 <= clk_en & w_done0;
            r_ack1 <= clk_en & w_done1;
            if (clk_en) begin
                r_state    <= w_state_nxt;
                r_last_gnt <= w_last_gnt_nxt;
                r_lock_vld <= w_lock_vld_nxt;
                r_lock_own <= w_lock_own_nxt;
                r_gnt0     <= (w_state_nxt == ST_ACC0);
                r_gnt1     <= (w_state_nxt == ST_ACC1);
                r_busy     <= (w_state_nxt != ST_IDLE);
                if (w_done0) begin
                    r_rdata0 <= mem_rdata_pi;
                end
                if (w_done1) begin
                    r_rdata1 <= mem_rdata_pi;
                end
            end
        end
    end

    // Memory port follows the registered owner; a dropped request deasserts the write at once.
    always_comb begin
        mem_addr_po  = 16'h0000;
        mem_wdata_po = 16'h0000;
        mem_write_po = 1'b0;
        case (r_state)
            ST_ACC0: begin
                mem_addr_po  = m0_addr_pi;
                mem_wdata_po = m0_wdata_pi;
                mem_write_po = m0_req_pi & m0_write_pi;
            end
            ST_ACC1: begin
                mem_addr_po  = m1_addr_pi;
                mem_wdata_po = m1_wdata_pi;
                mem_write_po = m1_req_pi & m1_write_pi;
            end
            default: begin
                mem_addr_po  = 16'h0000;
                mem_wdata_po = 16'h0000;
                mem_write_po = 1'b0;
            end
        endcase
    end

    assign m0_gnt_po   = r_gnt0;
    assign m1_gnt_po   = r_gnt1;
    assign m0_ack_po   = r_ack0;
    assign m1_ack_po   = r_ack1;
    assign m0_rdata_po = r_rdata0;
    assign m1_rdata_po = r_rdata1;
    assign busy_po     = r_busy;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Randomized and directed bench for mem_bus_arbiter against a transaction-level reference model.
`timescale 1ns/1ps
module tb_mem_bus_arbiter;
    localparam int LOCK_MAX = 4;
`ifdef ARB_LOCK_LIMIT_EN
    localparam bit LIMIT = 1'b1;
`else
    localparam bit LIMIT = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset_pi = 1'b0;
    logic clk_en = 1'b0;
    logic        req_v [2];
    logic        wr_v  [2];
    logic        lock_v[2];
    logic [15:0] addr_v[2];
    logic [15:0] wd_v  [2];
    logic        m0_gnt, m0_ack, m1_gnt, m1_ack, mem_write, busy;
    logic [15:0] m0_rdata, m1_rdata, mem_addr, mem_wdata, mem_rdata;
    logic [15:0] memarr[16];

    int n_checks = 0;
    int n_fail = 0;

    // Reference model state: owner index or -1, lock owner or -1.
    int          e_owner, e_last, e_lock_own, e_cnt;
    bit          e_ack[2];
    logic [15:0] e_rdata[2];

    bit auto_drive = 1'b0;
    bit viol_en = 1'b0;
    int lock_pct = 0;
    int en_mode = 0;
    int cyc = 0;
    bit s_en, s_we;
    logic [15:0] s_a, s_d;
    int n_commit, n_ack0, n_ack1, n_gnt0, n_gnt1;
    bit p_g0, p_g1;
    int gnt_log[$];

    function automatic logic [3:0] idx(input logic [15:0] a);
        return a[3:0] ^ a[15:12];
    endfunction

    assign mem_rdata = memarr[idx(mem_addr)];

    always #5 clk = ~clk;

    mem_bus_arbiter #(.LOCK_MAX(LOCK_MAX)) dut (
        .clk_pi(clk), .reset_pi(reset_pi), .clk_en(clk_en),
        .m0_req_pi(req_v[0]), .m0_write_pi(wr_v[0]), .m0_addr_pi(addr_v[0]),
        .m0_wdata_pi(wd_v[0]), .m0_lock_pi(lock_v[0]),
        .m0_gnt_po(m0_gnt), .m0_ack_po(m0_ack), .m0_rdata_po(m0_rdata),
        .m1_req_pi(req_v[1]), .m1_write_pi(wr_v[1]), .m1_addr_pi(addr_v[1]),
        .m1_wdata_pi(wd_v[1]), .m1_lock_pi(lock_v[1]),
        .m1_gnt_po(m1_gnt), .m1_ack_po(m1_ack), .m1_rdata_po(m1_rdata),
        .mem_addr_po(mem_addr), .mem_wdata_po(mem_wdata), .mem_write_po(mem_write),
        .mem_rdata_pi(mem_rdata), .busy_po(busy)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h expected=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        e_owner = -1; e_last = 1; e_lock_own = -1; e_cnt = 0;
        e_ack[0] = 1'b0; e_ack[1] = 1'b0;
        e_rdata[0] = 16'h0000; e_rdata[1] = 16'h0000;
    endtask

    // One enabled clock edge of the arbiter, written from the behavioural rules.
    task automatic model_step();
        e_ack[0] = 1'b0; e_ack[1] = 1'b0;
        if (!clk_en) return;
        if (e_owner < 0) begin
            int pick;
            pick = -1;
            if (e_lock_own >= 0 && !req_v[e_lock_own]) begin
                e_lock_own = -1; e_cnt = 0;
            end
            if (e_lock_own >= 0) begin
                int oth;
                oth = 1 - e_lock_own;
                if (LIMIT && e_cnt == LOCK_MAX && req_v[oth]) begin
                    pick = oth; e_cnt = 0;
                end else begin
                    pick = e_lock_own;
                    if (LIMIT && req_v[oth]) e_cnt++;
                end
            end else if (req_v[0] && req_v[1]) pick = 1 - e_last;
            else if (req_v[0]) pick = 0;
            else if (req_v[1]) pick = 1;
            if (pick >= 0) begin
                e_owner = pick; e_last = pick;
            end
        end else begin
            if (req_v[e_owner]) begin
                e_ack[e_owner] = 1'b1;
                e_rdata[e_owner] = memarr[idx(addr_v[e_owner])];
                if (lock_v[e_owner]) e_lock_own = e_owner;
                else begin e_lock_own = -1; e_cnt = 0; end
            end
            e_owner = -1;
        end
    endtask

    task automatic check_comb();
        logic [15:0] ea, ed;
        logic ew;
        ea = 16'h0000; ed = 16'h0000; ew = 1'b0;
        if (e_owner >= 0) begin
            ea = addr_v[e_owner]; ed = wd_v[e_owner]; ew = req_v[e_owner] & wr_v[e_owner];
        end
        check_eq("mem_addr", mem_addr, ea);
        check_eq("mem_wdata", mem_wdata, ed);
        check_eq("mem_write", mem_write, ew);
    endtask

    task automatic check_regs();
        check_eq("gnt0", m0_gnt, e_owner == 0);
        check_eq("gnt1", m1_gnt, e_owner == 1);
        check_eq("busy", busy, e_owner >= 0);
        check_eq("ack0", m0_ack, e_ack[0]);
        check_eq("ack1", m1_ack, e_ack[1]);
        check_eq("rdata0", m0_rdata, e_rdata[0]);
        check_eq("rdata1", m1_rdata, e_rdata[1]);
    endtask

    task automatic new_req(input int n);
        req_v[n] = 1'b1;
        wr_v[n] = 1'($urandom_range(0, 1));
        case ($urandom_range(0, 4))
            0: addr_v[n] = 16'h8000;
            1: addr_v[n] = 16'h9000;
            2: addr_v[n] = 16'h9002;
            3: addr_v[n] = 16'hF000;
            default: addr_v[n] = 16'($urandom);
        endcase
        wd_v[n] = 16'($urandom);
        lock_v[n] = ($urandom_range(0, 99) < lock_pct);
    endtask

    task automatic drive_auto();
        for (int n = 0; n < 2; n++) begin
            if (!req_v[n]) begin
                if ($urandom_range(0, 99) < 40) new_req(n);
            end else if (e_ack[n]) begin
                if ($urandom_range(0, 99) < 60) new_req(n);
                else begin req_v[n] = 1'b0; lock_v[n] = 1'b0; end
            end else if (viol_en && e_owner == n && $urandom_range(0, 99) < 5) begin
                req_v[n] = 1'b0; lock_v[n] = 1'b0;
            end
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        reset_pi = 1'b1;
        if (auto_drive) drive_auto();
        case (en_mode)
            0: clk_en = 1'b1;
            1: clk_en = (cyc % 4 == 0);
            default: clk_en = 1'($urandom_range(0, 1));
        endcase
        cyc++;
        #1;
        check_comb();
        s_en = clk_en; s_we = mem_write; s_a = mem_addr; s_d = mem_wdata;
        @(posedge clk);
        #1;
        model_step();
        check_regs();
        if (s_en && s_we) begin
            memarr[idx(s_a)] = s_d;
            n_commit++;
        end
        n_ack0 += int'(m0_ack); n_ack1 += int'(m1_ack);
        n_gnt0 += int'(m0_gnt); n_gnt1 += int'(m1_gnt);
        if (m0_gnt && !p_g0) gnt_log.push_back(0);
        if (m1_gnt && !p_g1) gnt_log.push_back(1);
        p_g0 = m0_gnt; p_g1 = m1_gnt;
    endtask

    task automatic clear_counts();
        n_commit = 0; n_ack0 = 0; n_ack1 = 0; n_gnt0 = 0; n_gnt1 = 0;
        gnt_log.delete();
    endtask

    // Asserts reset between edges; the following cycle() releases it.
    task automatic do_reset();
        @(negedge clk);
        reset_pi = 1'b0;
        #1;
        check_eq("rst_gnt0", m0_gnt, 1'b0);
        check_eq("rst_gnt1", m1_gnt, 1'b0);
        check_eq("rst_ack0", m0_ack, 1'b0);
        check_eq("rst_mem_write", mem_write, 1'b0);
        check_eq("rst_busy", busy, 1'b0);
        check_eq("rst_rdata0", m0_rdata, 16'h0000);
        model_reset();
        clk_en = 1'b0;
        cyc = 0;
        p_g0 = 1'b0; p_g1 = 1'b0;
        @(posedge clk);
        #1;
        check_regs();
    endtask

    task automatic xact(input int n, input logic w, input logic [15:0] a, input logic [15:0] d,
                        input logic lk, output int lat);
        bit got;
        got = 1'b0;
        lat = 0;
        req_v[n] = 1'b1; wr_v[n] = w; addr_v[n] = a; wd_v[n] = d; lock_v[n] = lk;
        for (int i = 0; i < 64 && !got; i++) begin
            cycle();
            lat++;
            if ((n == 0) ? m0_ack : m1_ack) got = 1'b1;
        end
        check_eq("xact_done", got, 1'b1);
        req_v[n] = 1'b0; lock_v[n] = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        bit seen;
        for (int i = 0; i < 16; i++) memarr[i] = 16'($urandom);
        for (int n = 0; n < 2; n++) begin
            req_v[n] = 1'b0; wr_v[n] = 1'b0; lock_v[n] = 1'b0;
            addr_v[n] = 16'h0000; wd_v[n] = 16'h0000;
        end
        model_reset();
        do_reset();

        // Single write: one grant cycle, one committed write, ack two edges after request.
        en_mode = 0;
        clear_counts();
        xact(0, 1'b1, 16'h9000, 16'h1234, 1'b0, lat);
        check_eq("wr_latency", lat, 2);
        check_eq("wr_commits", n_commit, 1);
        check_eq("wr_gnt_cycles", n_gnt0, 1);
        check_eq("wr_ack_cycles", n_ack0, 1);
        check_eq("wr_mem", memarr[idx(16'h9000)], 16'h1234);

        // Read data held across other master's accesses.
        memarr[idx(16'h8000)] = 16'h00A5;
        xact(1, 1'b0, 16'h8000, 16'h0000, 1'b0, lat);
        check_eq("rd_m1", m1_rdata, 16'h00A5);
        for (int k = 1; k <= 3; k++) xact(0, 1'b0, 16'(k), 16'h0000, 1'b0, lat);
        check_eq("rd_m1_held", m1_rdata, 16'h00A5);

        // Continuous contention alternates, starting with m0.
        do_reset();
        clear_counts();
        req_v[0] = 1'b1; req_v[1] = 1'b1; wr_v[0] = 1'b0; wr_v[1] = 1'b0;
        for (int i = 0; i < 12; i++) cycle();
        check_eq("rr_count", gnt_log.size() >= 4, 1'b1);
        for (int i = 0; i < 4 && i < gnt_log.size(); i++)
            check_eq($sformatf("rr_order%0d", i), gnt_log[i], i % 2);

        // m0 locked while m1 waits.
        do_reset();
        clear_counts();
        lock_v[0] = 1'b1;
        for (int i = 0; i < 30; i++) cycle();
        check_eq("lock_count", gnt_log.size() >= 6, 1'b1);
        for (int i = 0; i < 6 && i < gnt_log.size(); i++)
            check_eq($sformatf("lock_order%0d", i), gnt_log[i], (LIMIT && i == 5) ? 1 : 0);
        req_v[0] = 1'b0; req_v[1] = 1'b0; lock_v[0] = 1'b0;
        for (int i = 0; i < 4; i++) cycle();

        // Sparse clock enable: single write of 0x0001 to 0x9002.
        en_mode = 1;
        clear_counts();
        xact(1, 1'b1, 16'h9002, 16'h0001, 1'b0, lat);
        check_eq("ce_commits", n_commit, 1);
        check_eq("ce_ack_cycles", n_ack1, 1);
        check_eq("ce_gnt_cycles", n_gnt1, 4);
        check_eq("ce_mem", memarr[idx(16'h9002)], 16'h0001);

        // Reset in the middle of an m0 access, then fresh contention.
        en_mode = 0;
        req_v[0] = 1'b1; wr_v[0] = 1'b1; addr_v[0] = 16'hF000; wd_v[0] = 16'hBEEF;
        req_v[1] = 1'b1; wr_v[1] = 1'b0; addr_v[1] = 16'h8000;
        seen = 1'b0;
        for (int i = 0; i < 8 && !seen; i++) begin
            cycle();
            if (m0_gnt) seen = 1'b1;
        end
        check_eq("mid_gnt0", seen, 1'b1);
        do_reset();
        clear_counts();
        for (int i = 0; i < 3; i++) cycle();
        check_eq("post_rst_any", gnt_log.size() > 0, 1'b1);
        if (gnt_log.size() > 0) check_eq("post_rst_first", gnt_log[0], 0);
        req_v[0] = 1'b0; req_v[1] = 1'b0;
        for (int i = 0; i < 3; i++) cycle();

        // Random traffic across enable patterns, lock density and dropped requests.
        auto_drive = 1'b1;
        for (int ph = 0; ph < 3; ph++) begin
            en_mode = ph;
            lock_pct = (ph == 0) ? 60 : 25;
            viol_en = (ph == 2);
            for (int i = 0; i < 800; i++) cycle();
        end
        auto_drive = 1'b0;
        viol_en = 1'b0;
        req_v[0] = 1'b0; req_v[1] = 1'b0;
        en_mode = 0;
        for (int i = 0; i < 4; i++) cycle();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
